fifo_drain: RTL and testbench

FIFO_DRAIN -- requirements
Module: fifo_drain

---
 rtl/fifo_drain.sv | 114 +++++++++++
 tb/tb_fifo_drain.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/fifo_drain.sv
// fifo_drain: drains a show-ahead upstream FIFO into a 2-entry in-order output buffer.
// Latency: 1 cycle from FIFO read to out_valid when the buffer is empty; sustains 1 word/cycle.
// Backpressure: in_ready=0 holds out_valid/out_data; FIFO reads stop once both entries are full.
// Build option: define FIFO_DRAIN_COUNT_EN for a saturating 16-bit accepted-word counter on out_count.

module fifo_drain #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_fifo_data,
    input  logic              in_fifo_empty,
    output logic              out_fifo_read,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              in_ready,
    output logic [15:0]       out_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] head_q, head_d;   // oldest entry, drives out_data
    logic [DATA_W-1:0] tail_q, tail_d;   // second entry, only meaningful in TWO
    logic              push;
    logic              pop;

    // The FIFO read is gated by rst so no word is popped upstream while the
    // buffer is held in reset and could not capture it.
    assign out_fifo_read = rst & ~in_fifo_empty & (state_q != TWO);
    assign push          = out_fifo_read;
    assign out_valid     = (state_q != EMPTY);
    assign pop           = out_valid & in_ready;
    assign out_data      = head_q;

    // Next-state and buffer update: pop removes head, push appends newest word.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    head_d  = in_fifo_data;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (push && pop) begin
                    // Head leaves and the incoming word takes its place.
                    head_d = in_fifo_data;
                end else if (push) begin
                    tail_d  = in_fifo_data;
                    state_d = TWO;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                // No push is possible here; a pop promotes the second entry.
                if (pop) begin
                    head_d  = tail_q;
                    state_d = ONE;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // State and buffer registers; reset discards any buffered words.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

`ifdef FIFO_DRAIN_COUNT_EN
    logic [15:0] count_q, count_d;

    // Count accepted words, sticking at all-ones instead of wrapping.
    always_comb begin
        count_d = count_q;
        if (pop && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign out_count = count_q;
`else
    assign out_count = '0;
`endif

endmodule

// File: tb/tb_fifo_drain.sv
// tb_fifo_drain: randomized and directed stimulus against a queue-based reference model.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// The upstream FIFO is a queue that pops whenever the model expects a read.

module tb_fifo_drain;

    localparam int DW = 8;

    logic          clk;
    logic          rst;
    logic [DW-1:0] in_fifo_data;
    logic          in_fifo_empty;
    logic          out_fifo_read;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          in_ready;
    logic [15:0]   out_count;

    fifo_drain #(.DATA_W(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_fifo_data  (in_fifo_data),
        .in_fifo_empty (in_fifo_empty),
        .out_fifo_read (out_fifo_read),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .in_ready      (in_ready),
        .out_count     (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned    n_cmp = 0;
    int unsigned    n_err = 0;

    logic [DW-1:0]  up_q[$];    // upstream FIFO contents, head at index 0
    logic [DW-1:0]  mb[$];      // expected buffer contents, oldest first
    int unsigned    mcount = 0; // expected out_count
    int unsigned    n_reads = 0;
    int unsigned    n_valid_run = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle, entered and left on the falling edge.
    task automatic cycle(input bit rdy, input bit hold);
        bit exp_rd;
        bit pop;
        in_ready      = rdy;
        in_fifo_empty = hold || (up_q.size() == 0);
        in_fifo_data  = (up_q.size() != 0) ? up_q[0] : DW'($urandom);
        #1;
        exp_rd = !in_fifo_empty && (mb.size() < 2);
        pop    = (mb.size() != 0) && rdy;
        chk("read", {31'd0, out_fifo_read}, {31'd0, exp_rd});
        chk("valid", {31'd0, out_valid}, {31'd0, (mb.size() != 0)});
        if (mb.size() != 0) chk("data", {24'd0, out_data}, {24'd0, mb[0]});
        chk("count", {16'd0, out_count}, mcount);
        if (out_fifo_read && in_fifo_empty) chk("empty_guard", 32'd1, 32'd0);
        @(posedge clk);
        if (pop) begin
            void'(mb.pop_front());
`ifdef FIFO_DRAIN_COUNT_EN
            if (mcount != 32'hFFFF) mcount++;
`endif
        end
        if (exp_rd) begin
            mb.push_back(up_q.pop_front());
            n_reads++;
        end
        @(negedge clk);
    endtask

    // Reset asserted away from the rising edge; outputs must clear at once.
    task automatic do_reset(input string tag);
        rst           = 1'b0;
        in_fifo_empty = 1'b0;
        in_fifo_data  = 8'h5A;
        #1;
        chk({tag, "_read"},  {31'd0, out_fifo_read}, 32'd0);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_data"},  {24'd0, out_data}, 32'd0);
        chk({tag, "_count"}, {16'd0, out_count}, 32'd0);
        mb.delete();
        mcount = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int unsigned rd0;
        rst           = 1'b0;
        in_ready      = 1'b0;
        in_fifo_empty = 1'b0;
        in_fifo_data  = '0;
        @(negedge clk);
        do_reset("reset");

        // Single word: read in cycle 0, presented and accepted in cycle 1.
        up_q.push_back(8'hA5);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);

        // Backpressure: exactly two reads while stalled, head held stable.
        for (int i = 1; i <= 4; i++) up_q.push_back(DW'(i));
        rd0 = n_reads;
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0);
        chk("bp_reads", n_reads - rd0, 32'd2);
        chk("bp_up_left", up_q.size(), 32'd2);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0);

        // Streaming: 16 words, then 16 consecutive valid cycles.
        for (int i = 0; i < 16; i++) up_q.push_back(DW'($urandom));
        n_valid_run = 0;
        for (int i = 0; i < 18; i++) begin
            cycle(1'b1, 1'b0);
            if (out_valid) n_valid_run++;
        end
        chk("stream_valid_cycles", n_valid_run, 32'd16);

        // Random traffic with empty-flag toggling and backpressure.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(1, 0) == 1) up_q.push_back(DW'($urandom));
            cycle(($urandom_range(3, 0) != 0), ($urandom_range(2, 0) == 0));
        end
        for (int i = 0; i < 600 && (up_q.size() != 0 || mb.size() != 0); i++) cycle(1'b1, 1'b0);
        chk("drained", up_q.size() + mb.size(), 32'd0);

        // Mid-operation reset with the buffer full.
        up_q.push_back(8'h11);
        up_q.push_back(8'h22);
        up_q.push_back(8'h33);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);
        chk("two_full", mb.size(), 32'd2);
        do_reset("midreset");
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0);

`ifdef FIFO_DRAIN_COUNT_EN
        // Saturation: more than 65535 accepted words.
        for (int i = 0; i < 65540; i++) up_q.push_back(DW'(i));
        for (int i = 0; i < 65545; i++) cycle(1'b1, 1'b0);
        chk("sat_count", {16'd0, out_count}, 32'hFFFF);
        up_q.push_back(8'h77);
        up_q.push_back(8'h88);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);
        do_reset("satreset");
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
